// File: rtl/div_scheduler_if.sv
// Bundle between two requesters, the scheduler and the shared iterative divider.
// The slave modport is the scheduler's side; master is the surrounding environment.
interface div_scheduler_if #(
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] m0;
    logic [DATA_W-1:0] q1;
    logic [DATA_W-1:0] m1;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [DATA_W-1:0] quot;
    logic [DATA_W:0]   rem;
    logic              dbz;
    logic              busy;
    logic              div_start;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] div_m;
    logic [DATA_W-1:0] div_quot;
    logic [DATA_W:0]   div_rem;

    modport slave (
        input  req0, req1, q0, m0, q1, m1, div_quot, div_rem,
        output gnt, done, quot, rem, dbz, busy, div_start, div_q, div_m
    );

    modport master (
        output req0, req1, q0, m0, q1, m1, div_quot, div_rem,
        input  gnt, done, quot, rem, dbz, busy, div_start, div_q, div_m
    );
endinterface

// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one multi-cycle divider between two requesters.
// Divide-by-zero is resolved locally without ever starting the divider.
module div_scheduler #(
    parameter int DIV_LAT = 17
) (
    input logic            clk,
    input logic            rst,
    div_scheduler_if.slave bus
);
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       gnt_q,   gnt_d;
    logic [1:0]       done_q,  done_d;
    logic             busy_q,  busy_d;
    logic             start_q, start_d;
    logic             dbz_q,   dbz_d;
    logic             last_q,  last_d;
    logic [15:0]      quot_q,  quot_d;
    logic [16:0]      rem_q,   rem_d;
    logic [15:0]      opq_q,   opq_d;
    logic [15:0]      opm_q,   opm_d;
    logic             pick1;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    always_comb begin
        pick1 = bus.req1 && (!bus.req0 || !last_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        busy_d  = busy_q;
        start_d = start_q;
        dbz_d   = dbz_q;
        last_d  = last_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        opq_d   = opq_q;
        opm_d   = opm_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    opq_d   = pick1 ? bus.q1 : bus.q0;
                    opm_d   = pick1 ? bus.m1 : bus.m0;
                end
            end
            LOAD: begin
                if (opm_q == 16'h0000) begin
                    state_d = RESP;
                    quot_d  = 16'hFFFF;
                    rem_d   = {1'b0, opq_q};
                    dbz_d   = 1'b1;
                    done_d  = gnt_q;
                end else begin
                    state_d = RUN;
                    cnt_d   = '0;
                    start_d = 1'b1;
                end
            end
            RUN: begin
                // Results are sampled on the last cycle the start level is held.
                if (cnt_q == LAST_CNT) begin
                    state_d = RESP;
                    start_d = 1'b0;
                    quot_d  = bus.div_quot;
                    rem_d   = bus.div_rem;
                    dbz_d   = 1'b0;
                    done_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                cnt_d   = '0;
                last_d  = gnt_q[1];
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            dbz_q   <= 1'b0;
            last_q  <= 1'b1;
            quot_q  <= '0;
            rem_q   <= '0;
            opq_q   <= '0;
            opm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            dbz_q   <= dbz_d;
            last_q  <= last_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            opq_q   <= opq_d;
            opm_q   <= opm_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.div_start = start_q;
    assign bus.quot      = quot_q;
    assign bus.rem       = rem_q;
    assign bus.dbz       = dbz_q;
    assign bus.div_q     = opq_q;
    assign bus.div_m     = opm_q;
endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural divider that only presents
// a valid result on the DIV_LAT-th consecutive start cycle.
module tb_div_scheduler;
    localparam int DIV_LAT = 17;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   dcnt  = 0;

    always #5 clk = ~clk;

    div_scheduler_if bus ();

    div_scheduler #(.DIV_LAT(DIV_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Divider clears while start is low; junk is shown until the result is due.
    always @(posedge clk) begin
        if (!bus.div_start) dcnt <= 0;
        else                dcnt <= dcnt + 1;
    end

    always_comb begin
        bus.div_quot = 16'hDEAD;
        bus.div_rem  = 17'h1BEEF;
        if (bus.div_start && dcnt == DIV_LAT - 1 && bus.div_m != 16'h0000) begin
            bus.div_quot = bus.div_q / bus.div_m;
            bus.div_rem  = {1'b0, bus.div_q % bus.div_m};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples one negedge per cycle, c=0 being the first; stops at the first done.
    task automatic watch(input int budget, input int drop_at, input logic [1:0] drop_mask,
                         output int t_gnt, output int t_done, output int t_s0,
                         output int n_s, output logic [1:0] g, output logic [1:0] d);
        t_gnt = -1; t_done = -1; t_s0 = -1; n_s = 0; g = 2'b00; d = 2'b00;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (c == drop_at) begin
                if (drop_mask[0]) begin bus.req0 = 1'b0; bus.q0 = 16'h0; bus.m0 = 16'h0; end
                if (drop_mask[1]) begin bus.req1 = 1'b0; bus.q1 = 16'h0; bus.m1 = 16'h0; end
            end
            chk("gnt_onehot", 64'($countones(bus.gnt) <= 1), 64'd1);
            chk("done_onehot", 64'($countones(bus.done) <= 1), 64'd1);
            if (bus.gnt != 2'b00 && t_gnt < 0) begin t_gnt = c; g = bus.gnt; end
            if (bus.div_start) begin
                if (t_s0 < 0) t_s0 = c;
                n_s++;
            end
            if (bus.done != 2'b00) begin t_done = c; d = bus.done; break; end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int         tg, td, ts, ns;
    logic [1:0] g, d;

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.q0 = 16'h0; bus.m0 = 16'h0; bus.q1 = 16'h0; bus.m1 = 16'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", bus.gnt, 2'b00);
        chk("rst_done", bus.done, 2'b00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_start", bus.div_start, 1'b0);
        chk("rst_quot", bus.quot, 16'h0);
        chk("rst_rem", bus.rem, 17'h0);
        chk("rst_dbz", bus.dbz, 1'b0);
        chk("rst_divq", bus.div_q, 16'h0);
        next_cycle();
        rst = 1'b0;

        // 7 / 3 from requester 0
        next_cycle();
        bus.req0 = 1'b1; bus.q0 = 16'd7; bus.m0 = 16'd3;
        watch(40, -1, 2'b00, tg, td, ts, ns, g, d);
        chk("t1_tgnt", tg, 1);
        chk("t1_gnt", g, 2'b01);
        chk("t1_sfirst", ts, 2);
        chk("t1_nstart", ns, 17);
        chk("t1_tdone", td, 19);
        chk("t1_done", d, 2'b01);
        chk("t1_quot", bus.quot, 16'd2);
        chk("t1_rem", bus.rem, 17'd1);
        chk("t1_dbz", bus.dbz, 1'b0);
        bus.req0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_hold_quot", bus.quot, 16'd2);
        chk("t1_idle_gnt", bus.gnt, 2'b00);
        chk("t1_idle_busy", bus.busy, 1'b0);
        chk("t1_idle_done", bus.done, 2'b00);

        // Divide by zero from requester 1
        next_cycle();
        bus.req1 = 1'b1; bus.q1 = 16'h1234; bus.m1 = 16'h0;
        watch(40, -1, 2'b00, tg, td, ts, ns, g, d);
        chk("t2_tgnt", tg, 1);
        chk("t2_gnt", g, 2'b10);
        chk("t2_nstart", ns, 0);
        chk("t2_tdone", td, 2);
        chk("t2_done", d, 2'b10);
        chk("t2_quot", bus.quot, 16'hFFFF);
        chk("t2_rem", bus.rem, 17'h01234);
        chk("t2_dbz", bus.dbz, 1'b1);
        bus.req1 = 1'b0;

        // Tie after reset: 0 first, 1 pending, then 0 wins the next tie
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0;
        next_cycle();
        bus.req0 = 1'b1; bus.q0 = 16'd100; bus.m0 = 16'd7;
        bus.req1 = 1'b1; bus.q1 = 16'd50;  bus.m1 = 16'd6;
        watch(40, -1, 2'b00, tg, td, ts, ns, g, d);
        chk("t3a_gnt", g, 2'b01);
        chk("t3a_tdone", td, 19);
        chk("t3a_quot", bus.quot, 16'd14);
        chk("t3a_rem", bus.rem, 17'd2);
        bus.req0 = 1'b0;
        watch(40, -1, 2'b00, tg, td, ts, ns, g, d);
        chk("t3b_tgnt", tg, 1);
        chk("t3b_gnt", g, 2'b10);
        chk("t3b_tdone", td, 19);
        chk("t3b_done", d, 2'b10);
        chk("t3b_quot", bus.quot, 16'd8);
        chk("t3b_rem", bus.rem, 17'd2);
        bus.req1 = 1'b0;
        next_cycle();
        bus.req0 = 1'b1; bus.q0 = 16'd9; bus.m0 = 16'd9;
        bus.req1 = 1'b1;
        watch(40, -1, 2'b00, tg, td, ts, ns, g, d);
        chk("t3c_gnt", g, 2'b01);
        chk("t3c_quot", bus.quot, 16'd1);
        chk("t3c_rem", bus.rem, 17'd0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Both held for four operations: strict alternation and start gaps
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0;
        next_cycle();
        bus.req0 = 1'b1; bus.q0 = 16'd1000; bus.m0 = 16'd10;
        bus.req1 = 1'b1; bus.q1 = 16'd1001; bus.m1 = 16'd10;
        for (int k = 0; k < 4; k++) begin
            watch(40, -1, 2'b00, tg, td, ts, ns, g, d);
            chk("t4_gnt", g, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t4_done", d, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t4_sfirst", ts, 2);
            chk("t4_tdone", td, 19);
            chk("t4_quot", bus.quot, 16'd100);
            chk("t4_rem", bus.rem, (k % 2 == 0) ? 17'd0 : 17'd1);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Reset during RUN abandons the operation; held request restarts
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0;
        next_cycle();
        bus.req0 = 1'b1; bus.q0 = 16'd7; bus.m0 = 16'd3;
        repeat (11) @(negedge clk);
        chk("t5_run_start", bus.div_start, 1'b1);
        chk("t5_run_busy", bus.busy, 1'b1);
        chk("t5_run_gnt", bus.gnt, 2'b01);
        rst = 1'b1;
        #1;
        chk("t5_rst_gnt", bus.gnt, 2'b00);
        chk("t5_rst_busy", bus.busy, 1'b0);
        chk("t5_rst_start", bus.div_start, 1'b0);
        chk("t5_rst_done", bus.done, 2'b00);
        chk("t5_rst_quot", bus.quot, 16'h0);
        chk("t5_rst_rem", bus.rem, 17'h0);
        chk("t5_rst_divq", bus.div_q, 16'h0);
        next_cycle();
        rst = 1'b0;
        watch(40, -1, 2'b00, tg, td, ts, ns, g, d);
        chk("t5_tdone", td, 19);
        chk("t5_done", d, 2'b01);
        chk("t5_quot", bus.quot, 16'd2);
        chk("t5_rem", bus.rem, 17'd1);
        bus.req0 = 1'b0;

        // Max dividend; requester drops req and scrambles operands mid-run
        next_cycle();
        bus.req0 = 1'b1; bus.q0 = 16'hFFFF; bus.m0 = 16'd1;
        watch(40, 5, 2'b01, tg, td, ts, ns, g, d);
        chk("t6_tdone", td, 19);
        chk("t6_done", d, 2'b01);
        chk("t6_quot", bus.quot, 16'hFFFF);
        chk("t6_rem", bus.rem, 17'h0);
        chk("t6_dbz", bus.dbz, 1'b0);
        repeat (2) @(negedge clk);
        chk("t6_idle_busy", bus.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 Parameter DIV_LAT, default 17: number of cycles div_start is held high per operation (divider latency); legal range 1..63.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1; held high until that requester's done pulse.
REQ-005 q0, m0, q1, m1  input  16 each  dividend / divisor of each requester; stable while its req is high.
REQ-006 gnt  output  2  one-hot grant, bit k = requester k owns the divider.
REQ-007 done  output  2  one-cycle pulse, bit k = result for requester k valid.
REQ-008 quot  output  16  quotient of the last completed operation.
REQ-009 rem  output  17  remainder of the last completed operation.
REQ-010 dbz  output  1  divide-by-zero flag of the last completed operation.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 div_start  output  1  level start to the shared divider; the divider clears its internal state while low.
REQ-013 div_q, div_m  output  16 each  operands to the divider.
REQ-014 div_quot  input  16  and  div_rem  input  17  divider results, valid at the end of the DIV_LAT-th start cycle.

Function
REQ-015 States: IDLE, LOAD, RUN, RESP, encoded in one state register.
REQ-016 IDLE: if req0 or req1 is high, select the winner, latch its q/m into operand registers, set gnt, and go to LOAD; else stay.
REQ-017 Arbitration is round-robin: with a single requester, it wins; with both, the requester not served last wins; last-served resets to 1 so requester 0 wins the first tie.
REQ-018 LOAD: div_start low, div_q/div_m driven from operand registers; if latched divisor is 0, go to RESP with dbz result, else go to RUN with cycle counter cleared.
REQ-019 RUN: div_start high, counter increments each cycle; on the cycle counter equals DIV_LAT-1, capture div_quot into quot, div_rem into rem, clear dbz, and go to RESP.
REQ-020 Divide-by-zero result: quot = 16'hFFFF, rem = {1'b0, dividend}, dbz = 1; divider never started.
REQ-021 RESP: div_start low, done bit of the granted requester high for exactly this cycle, update last-served, then go to IDLE.
REQ-022 gnt is high from LOAD through RESP inclusive and zero in IDLE.
REQ-023 Latency: req seen in IDLE at cycle 0 -> done at cycle DIV_LAT+2 (19 for default); divide-by-zero -> done at cycle 2.
REQ-024 div_start is low for at least 2 cycles (RESP + IDLE) between consecutive operations.
REQ-025 A requester that drops req mid-operation does not abort it; the operation completes and its done still pulses.
REQ-026 The other requester's req arriving mid-operation is held pending and arbitrated in the next IDLE.
REQ-027 quot, rem, dbz hold their values until the next completion; they change only on the RUN->RESP or LOAD->RESP transition.
REQ-028 div_q/div_m equal the operand registers at all times; operand registers change only on the IDLE->LOAD transition.
REQ-029 At most one gnt bit and one done bit are high in any cycle.

Reset
REQ-030 rst high forces, asynchronously: state IDLE, counter 0, gnt 0, done 0, busy 0, div_start 0, quot 0, rem 0, dbz 0, operand registers 0, last-served 1.
REQ-031 Reset mid-operation abandons it with no done pulse; after rst falls, a still-high req is arbitrated afresh from IDLE.

Verification
REQ-032 req0 with q0=7, m0=3 -> gnt=01 cycle 1, div_start high cycles 2..18, done=01 cycle 19, quot=2, rem=1, dbz=0.
REQ-033 req1 with q1=16'h1234, m1=0 -> div_start never high, done=10 cycle 2, quot=16'hFFFF, rem=17'h01234, dbz=1.
REQ-034 req0 and req1 raised same cycle after reset, both held -> requester 0 served first, requester 1 granted in the IDLE after done0; next tie goes to requester 0 again.
REQ-035 Both requesters held continuously for 4 operations -> grants alternate 0,1,0,1; div_start low at least 2 cycles between runs.
REQ-036 rst pulsed during RUN (cycle 10) -> all outputs zero immediately, no done; req0 still high -> new operation completes with done 19 cycles after rst release.
REQ-037 q0=16'hFFFF, m0=1 -> quot=16'hFFFF, rem=0, dbz=0 at done.
